// File: rtl/lz4_pkg.sv
// Shared LZ4 sequence-encoder definitions: FSM encoding, format constants and the
// token-nibble helper.
package lz4_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StLitExt,
        StLitData,
        StOffLo,
        StOffHi,
        StMatExt
    } lz4_state_e;

    localparam int unsigned LZ4_MIN_MATCH  = 4;
    localparam int unsigned LZ4_NIBBLE_MAX = 15;
    localparam int unsigned LZ4_EXT_MAX    = 255;

    function automatic logic [3:0] lz4_nibble(input logic [31:0] len);
        return (len >= LZ4_NIBBLE_MAX) ? 4'hF : len[3:0];
    endfunction

endpackage

// File: rtl/lz4_len_ext.sv
// LZ4 length-extension byte generator: loads a full length L and, when L >= 15, emits
// floor((L-15)/255) bytes of 0xFF then the remainder byte under a valid/ready handshake.
module lz4_len_ext
    import lz4_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             ext_valid,
    input  logic             ext_ready,
    output logic [7:0]       ext_data,
    output logic             ext_last
);

    localparam logic [LEN_W-1:0] NibMax = LEN_W'(LZ4_NIBBLE_MAX);
    localparam logic [LEN_W-1:0] ExtMax = LEN_W'(LZ4_EXT_MAX);

    logic [LEN_W-1:0] rem_q;
    logic             active_q;

    // Remainder is tested against 255 before any subtraction, so it never underflows.
    assign ext_last  = (rem_q < ExtMax);
    assign ext_data  = ext_last ? rem_q[7:0] : 8'hFF;
    assign ext_valid = active_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            active_q <= (len >= NibMax);
            rem_q    <= (len >= NibMax) ? (len - NibMax) : '0;
        end else if (active_q && ext_ready) begin
            if (ext_last) begin
                active_q <= 1'b0;
                rem_q    <= '0;
            end else begin
                rem_q <= rem_q - ExtMax;
            end
        end
    end

endmodule

// File: rtl/lz4_seq_encoder.sv
// LZ4 sequence encoder: turns (lit_len, match_len, offset, last) commands plus a literal
// byte stream into LZ4 block bytes. Optional byte counter: define LZ4_ENC_BYTE_COUNT_EN.
module lz4_seq_encoder
    import lz4_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_lit_len,
    input  logic [LEN_W-1:0] cmd_match_len,
    input  logic [15:0]      cmd_offset,
    input  logic             cmd_last,
    input  logic             lit_valid,
    output logic             lit_ready,
    input  logic [7:0]       lit_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             o_idle,
    output logic             o_err
`ifdef LZ4_ENC_BYTE_COUNT_EN
    ,
    output logic [31:0]      o_byte_count
`endif
);

    localparam logic [LEN_W-1:0] MinMatch = LEN_W'(LZ4_MIN_MATCH);
    localparam logic [LEN_W-1:0] One      = LEN_W'(1);

    lz4_state_e       state_q;
    logic [LEN_W-1:0] lit_cnt_q;
    logic [15:0]      offset_q;
    logic             last_q;
    logic [7:0]       token_q;
    logic             err_q;

    logic             cmd_fire;
    logic             cmd_bad;
    logic             cmd_load;
    logic [LEN_W-1:0] mat_len_m4;
    logic             out_fire;
    lz4_state_e       lit_done_state;

    logic             lit_ext_valid, lit_ext_ready, lit_ext_last;
    logic [7:0]       lit_ext_data;
    logic             mat_ext_valid, mat_ext_ready, mat_ext_last;
    logic [7:0]       mat_ext_data;

    assign cmd_ready  = rstn && (state_q == StIdle);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_bad    = !cmd_last && ((cmd_match_len < MinMatch) || (cmd_offset == 16'h0000));
    assign cmd_load   = cmd_fire && !cmd_bad;
    assign mat_len_m4 = cmd_match_len - MinMatch;
    assign out_fire   = out_valid && out_ready;
    assign o_idle     = !rstn || (state_q == StIdle);
    assign o_err      = rstn && err_q;

    assign lit_done_state = last_q ? StIdle : StOffLo;

    lz4_len_ext #(.LEN_W(LEN_W)) u_lit_ext (
        .clk       (clk),
        .rstn      (rstn),
        .load      (cmd_load),
        .len       (cmd_lit_len),
        .ext_valid (lit_ext_valid),
        .ext_ready (lit_ext_ready),
        .ext_data  (lit_ext_data),
        .ext_last  (lit_ext_last)
    );

    // A last command has no match part, so a zero length keeps the match extension idle.
    lz4_len_ext #(.LEN_W(LEN_W)) u_mat_ext (
        .clk       (clk),
        .rstn      (rstn),
        .load      (cmd_load),
        .len       (cmd_last ? '0 : mat_len_m4),
        .ext_valid (mat_ext_valid),
        .ext_ready (mat_ext_ready),
        .ext_data  (mat_ext_data),
        .ext_last  (mat_ext_last)
    );

    always_comb begin
        out_valid     = 1'b0;
        out_data      = 8'h00;
        out_last      = 1'b0;
        lit_ready     = 1'b0;
        lit_ext_ready = 1'b0;
        mat_ext_ready = 1'b0;
        case (state_q)
            StToken: begin
                out_valid = 1'b1;
                out_data  = token_q;
                out_last  = last_q && (lit_cnt_q == '0);
            end
            StLitExt: begin
                out_valid     = lit_ext_valid;
                out_data      = lit_ext_data;
                lit_ext_ready = out_ready;
            end
            StLitData: begin
                out_valid = lit_valid;
                out_data  = lit_data;
                lit_ready = out_ready;
                out_last  = last_q && (lit_cnt_q == One);
            end
            StOffLo: begin
                out_valid = 1'b1;
                out_data  = offset_q[7:0];
            end
            StOffHi: begin
                out_valid = 1'b1;
                out_data  = offset_q[15:8];
            end
            StMatExt: begin
                out_valid     = mat_ext_valid;
                out_data      = mat_ext_data;
                mat_ext_ready = out_ready;
            end
            default: ;
        endcase
        if (!rstn) begin
            out_valid     = 1'b0;
            out_data      = 8'h00;
            out_last      = 1'b0;
            lit_ready     = 1'b0;
            lit_ext_ready = 1'b0;
            mat_ext_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            lit_cnt_q <= '0;
            offset_q  <= '0;
            last_q    <= 1'b0;
            token_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            lit_cnt_q <= cmd_lit_len;
                            offset_q  <= cmd_offset;
                            last_q    <= cmd_last;
                            token_q   <= {lz4_nibble(32'(cmd_lit_len)),
                                          cmd_last ? 4'h0 : lz4_nibble(32'(mat_len_m4))};
                            state_q   <= StToken;
                        end
                    end
                end
                StToken: begin
                    if (out_fire) begin
                        if (lit_ext_valid)          state_q <= StLitExt;
                        else if (lit_cnt_q != '0)   state_q <= StLitData;
                        else                        state_q <= lit_done_state;
                    end
                end
                StLitExt: begin
                    if (out_fire && lit_ext_last) begin
                        state_q <= (lit_cnt_q != '0) ? StLitData : lit_done_state;
                    end
                end
                StLitData: begin
                    if (out_fire) begin
                        lit_cnt_q <= lit_cnt_q - One;
                        if (lit_cnt_q == One) state_q <= lit_done_state;
                    end
                end
                StOffLo: begin
                    if (out_fire) state_q <= StOffHi;
                end
                StOffHi: begin
                    if (out_fire) state_q <= mat_ext_valid ? StMatExt : StIdle;
                end
                StMatExt: begin
                    if (out_fire && mat_ext_last) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LZ4_ENC_BYTE_COUNT_EN
    logic [31:0] byte_count_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_count_q <= '0;
        end else if (out_fire) begin
            byte_count_q <= byte_count_q + 32'd1;
        end
    end

    assign o_byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_lz4_seq_encoder.sv
// Scoreboard bench for lz4_seq_encoder: directed commands push expected bytes, a monitor
// pops and compares every accepted output byte.
module tb_lz4_seq_encoder;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_lit_len = '0;
    logic [LEN_W-1:0] cmd_match_len = '0;
    logic [15:0]      cmd_offset = '0;
    logic             cmd_last = 1'b0;
    logic             lit_valid = 1'b0;
    logic             lit_ready;
    logic [7:0]       lit_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_last;
    logic             o_idle;
    logic             o_err;
`ifdef LZ4_ENC_BYTE_COUNT_EN
    logic [31:0]      o_byte_count;
`endif

    always #5 clk = ~clk;

    lz4_seq_encoder #(.LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_lit_len   (cmd_lit_len),
        .cmd_match_len (cmd_match_len),
        .cmd_offset    (cmd_offset),
        .cmd_last      (cmd_last),
        .lit_valid     (lit_valid),
        .lit_ready     (lit_ready),
        .lit_data      (lit_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .o_idle        (o_idle),
        .o_err         (o_err)
`ifdef LZ4_ENC_BYTE_COUNT_EN
        ,
        .o_byte_count  (o_byte_count)
`endif
    );

    logic [8:0] exp_q[$];     // {last, data}
    logic [7:0] lit_src[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         byte_cnt = 0;
    int         bytes_since_rst = 0;
    bit         throttle = 1'b0;
    bit         lit_fired = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, between input updates and the active edge.
    initial begin
        forever begin
            @(negedge clk);
            lit_fired = lit_valid && lit_ready && rstn;
            if (!rstn) begin
                stalled = 1'b0;
                bytes_since_rst = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_data_held", out_data, stall_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_byte: got %0h, expected no byte", out_data);
                    end else begin
                        check("out_byte", {out_last, out_data}, exp_q.pop_front());
                    end
                    byte_cnt++;
                    bytes_since_rst++;
                end
                stalled    = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    // Literal source and output-ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (lit_fired) begin
                void'(lit_src.pop_front());
                lit_valid = 1'b0;
                lit_fired = 1'b0;
            end
            if (!lit_valid && lit_src.size() > 0 &&
                (!throttle || $urandom_range(0, 2) != 0)) begin
                lit_valid = 1'b1;
                lit_data  = lit_src[0];
            end
            out_ready = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic send_cmd(input int lit, input int mlen, input int off, input logic last);
        bit done = 1'b0;
        @(posedge clk);
        #2;
        cmd_valid     = 1'b1;
        cmd_lit_len   = LEN_W'(lit);
        cmd_match_len = LEN_W'(mlen);
        cmd_offset    = 16'(off);
        cmd_last      = last;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL cmd_handshake_timeout: got no cmd_ready, expected it within 500 cycles");
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && lit_src.size() == 0 && o_idle) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    task automatic seq_030();
        push_exp(8'h30, 0); push_exp(8'h41, 0); push_exp(8'h42, 0); push_exp(8'h43, 1);
        lit_src.push_back(8'h41); lit_src.push_back(8'h42); lit_src.push_back(8'h43);
        send_cmd(3, 0, 0, 1'b1);
        drain("drain_lit3_last");
    endtask

    task automatic seq_032();
        push_exp(8'h2F, 0); push_exp(8'hAA, 0); push_exp(8'hBB, 0);
        push_exp(8'h34, 0); push_exp(8'h12, 0); push_exp(8'hFF, 0); push_exp(8'h00, 0);
        lit_src.push_back(8'hAA); lit_src.push_back(8'hBB);
        send_cmd(2, 274, 16'h1234, 1'b0);
        drain("drain_match274");
    endtask

    task automatic load_033();
        push_exp(8'hF0, 0); push_exp(8'h00, 0);
        for (int i = 0; i < 15; i++) begin
            push_exp(8'(8'h60 + i), (i == 14));
            lit_src.push_back(8'(8'h60 + i));
        end
    endtask

    initial begin
        int base;
        bit reached;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_lit_ready", lit_ready, 0);
        check("rst_o_err", o_err, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_o_idle", o_idle, 1);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        seq_030();

        push_exp(8'h00, 0); push_exp(8'h01, 0); push_exp(8'h00, 0);
        send_cmd(0, 4, 1, 1'b0);
        drain("drain_min_match");
        check("idle_after_min_match", o_idle, 1);

        seq_032();

        load_033();
        send_cmd(15, 0, 0, 1'b1);
        drain("drain_lit15_last");

        // Throttled repeat must give the identical stream
        throttle = 1'b1;
        seq_032();
        throttle = 1'b0;

        // Illegal commands: consumed, one-cycle error pulse, no output
        base = byte_cnt;
        send_cmd(2, 3, 5, 1'b0);
        @(negedge clk);
        check("err_pulse_short_match", o_err, 1);
        @(negedge clk);
        check("err_pulse_ends", o_err, 0);
        check("idle_after_illegal", o_idle, 1);
        send_cmd(0, 4, 0, 1'b0);
        @(negedge clk);
        check("err_pulse_zero_offset", o_err, 1);
        repeat (4) @(negedge clk);
        check("no_bytes_on_illegal", byte_cnt - base, 0);

        // Reset during literal data
        base = byte_cnt;
        load_033();
        send_cmd(15, 0, 0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (byte_cnt - base >= 5) reached = 1'b1;
        end
        check("reach_lit_data", reached, 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        lit_src.delete();
        lit_valid = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_o_idle", o_idle, 1);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("post_abort_out_valid", out_valid, 0);
        check("post_abort_o_idle", o_idle, 1);

        seq_030();
`ifdef LZ4_ENC_BYTE_COUNT_EN
        check("byte_count", o_byte_count, 32'(bytes_since_rst));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
